// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory request/ready/rvalid bus from
// the EX/MEM register, formats load data by func3, and registers the MEM/WB fields.
// Ports: me_* in (EX/MEM), dmem_* bus, mem_stall out (comb), mem_exc/bus_err pulses, wb_* out (regs).
module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] me_regs_data2,
    input  logic [31:0] me_alu_o,
    input  logic [4:0]  me_rd,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic        me_mem2reg,
    input  logic        me_regs_write,
    input  logic [2:0]  me_func3_code,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_exc,
    output logic        bus_err,
    output logic [31:0] wb_alu_o,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regs_write,
    output logic        wb_mem2reg
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        lat_off;
    logic [2:0]        lat_f3;

    logic is_mem, illegal, misaligned, bad_op, legal_mem;
    logic load_done, timeout, cnt_clr, cnt_inc;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] fmt_data;

    // Operation classification
    always_comb begin
        is_mem  = me_mem_read | me_mem_write;
        illegal = 1'b0;
        if (me_mem_read && me_mem_write)
            illegal = 1'b1;
        else if (me_mem_read)
            illegal = !(me_func3_code inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (me_mem_write)
            illegal = !(me_func3_code inside {3'b000, 3'b001, 3'b010});
        misaligned = (me_func3_code[1:0] == 2'b01 && me_alu_o[0]) ||
                     (me_func3_code[1:0] == 2'b10 && me_alu_o[1:0] != 2'b00);
        bad_op    = is_mem && (illegal || misaligned);
        legal_mem = is_mem && !bad_op;
    end

    // Bus fields come straight from me_*; upstream holds them stable while stalled,
    // which keeps addr/wdata/wstrb constant across REQ.
    always_comb begin
        dmem_we    = me_mem_write;
        dmem_addr  = {me_alu_o[31:2], 2'b00};
        dmem_wdata = me_regs_data2;
        dmem_wstrb = 4'b0000;
        case (me_func3_code[1:0])
            2'b00:   dmem_wdata = {4{me_regs_data2[7:0]}};
            2'b01:   dmem_wdata = {2{me_regs_data2[15:0]}};
            default: dmem_wdata = me_regs_data2;
        endcase
        if (me_mem_write && legal_mem) begin
            case (me_func3_code[1:0])
                2'b00:   dmem_wstrb = 4'b0001 << me_alu_o[1:0];
                2'b01:   dmem_wstrb = 4'b0011 << me_alu_o[1:0];
                default: dmem_wstrb = 4'b1111;
            endcase
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nx  = state;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        load_done = 1'b0;
        timeout   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (legal_mem) begin
                    dmem_req = 1'b1;
                    if (me_mem_write) begin
                        mem_stall = !dmem_ready;
                        if (!dmem_ready) state_nx = REQ;
                    end else begin
                        mem_stall = 1'b1;
                        if (dmem_ready) begin
                            state_nx = WAIT;
                            cnt_clr  = 1'b1;
                        end else begin
                            state_nx = REQ;
                        end
                    end
                end
            end
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem_ready) begin
                    if (me_mem_write) begin
                        mem_stall = 1'b0;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = WAIT;
                        cnt_clr  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    load_done = 1'b1;
                    state_nx  = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Load data formatting with the offset/func3 latched at request time
    always_comb begin
        case (lat_off)
            2'd0:    sel_b = dmem_rdata[7:0];
            2'd1:    sel_b = dmem_rdata[15:8];
            2'd2:    sel_b = dmem_rdata[23:16];
            default: sel_b = dmem_rdata[31:24];
        endcase
        sel_h = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3)
            3'b000:  fmt_data = {{24{sel_b[7]}}, sel_b};
            3'b001:  fmt_data = {{16{sel_h[15]}}, sel_h};
            3'b100:  fmt_data = {24'd0, sel_b};
            3'b101:  fmt_data = {16'd0, sel_h};
            default: fmt_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_off       <= 2'd0;
            lat_f3        <= 3'd0;
            mem_exc       <= 1'b0;
            bus_err       <= 1'b0;
            wb_alu_o      <= 32'd0;
            wb_mem_data   <= 32'd0;
            wb_rd         <= 5'd0;
            wb_regs_write <= 1'b0;
            wb_mem2reg    <= 1'b0;
        end else begin
            state   <= state_nx;
            mem_exc <= (state == IDLE) && bad_op;
            bus_err <= timeout;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (state == IDLE) begin
                lat_off <= me_alu_o[1:0];
                lat_f3  <= me_func3_code;
            end
            if (mem_stall) begin
                // Bubble into WB; other fields keep their last values
                wb_regs_write <= 1'b0;
            end else begin
                wb_alu_o      <= me_alu_o;
                wb_rd         <= me_rd;
                wb_mem2reg    <= me_mem2reg;
                wb_regs_write <= me_regs_write && !timeout && !((state == IDLE) && bad_op);
                wb_mem_data   <= load_done ? fmt_data : 32'd0;
            end
        end
    end

endmodule
